// File: rtl/operand_registers.sv
// SAP-1 accumulator (A) and B operand registers with tri-state A bus drive.
// Optional Z/N flags on A loads when OPERAND_REGISTERS_FLAGS_EN is defined.
module operand_registers #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR_bar,
  input  logic [WIDTH-1:0] bus_input,
  input  logic             L_A,
  input  logic             E_A,
  input  logic             L_B,
  output logic [WIDTH-1:0] a_output,
  output logic [WIDTH-1:0] b_output,
  output logic [WIDTH-1:0] bus_output,
  output logic             flag_Z,
  output logic             flag_N
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      a_q <= '0;
    end else if (!L_A) begin
      a_q <= bus_input;
    end
  end

  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      b_q <= '0;
    end else if (!L_B) begin
      b_q <= bus_input;
    end
  end

  assign a_output   = a_q;
  assign b_output   = b_q;
  assign bus_output = E_A ? a_q : {WIDTH{1'bz}};

`ifdef OPERAND_REGISTERS_FLAGS_EN
  logic z_q;
  logic n_q;

  // Flags track the value entering A, so they match A after reset too.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      z_q <= 1'b1;
      n_q <= 1'b0;
    end else if (!L_A) begin
      z_q <= (bus_input == '0);
      n_q <= bus_input[WIDTH-1];
    end
  end

  assign flag_Z = z_q;
  assign flag_N = n_q;
`else
  assign flag_Z = 1'b0;
  assign flag_N = 1'b0;
`endif

endmodule

// File: tb/tb_operand_registers.sv
// Scoreboard bench for operand_registers: a second bus driver stands in
// for the rest of the W bus whenever the accumulator releases it.
module tb_operand_registers;

`ifdef OPERAND_REGISTERS_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam logic [7:0] OTHER = 8'h3C;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] bus;
    logic       fz;
    logic       fn;
  } exp_t;

  logic       CLK = 1'b0;
  logic       CLR_bar;
  logic [7:0] bus_input;
  logic       L_A;
  logic       E_A;
  logic       L_B;
  logic [7:0] a_output;
  logic [7:0] b_output;
  wire  [7:0] bus_w;
  logic       flag_Z;
  logic       flag_N;

  exp_t q[$];
  event mon_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign bus_w = E_A ? 8'bz : OTHER;

  operand_registers #(.WIDTH(8)) dut (
    .CLK(CLK),
    .CLR_bar(CLR_bar),
    .bus_input(bus_input),
    .L_A(L_A),
    .E_A(E_A),
    .L_B(L_B),
    .a_output(a_output),
    .b_output(b_output),
    .bus_output(bus_w),
    .flag_Z(flag_Z),
    .flag_N(flag_N)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] a,
                     input logic [7:0] b, input logic fz,
                     input logic fn);
    exp_t e;
    e.name = n;
    e.a    = a;
    e.b    = b;
    e.bus  = E_A ? a : OTHER;
    e.fz   = FE & fz;
    e.fn   = FE & fn;
    q.push_back(e);
    ->mon_ev;
    #1;
  endtask

  task automatic cmp8(input string n, input string f,
                      input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  task automatic cmp1(input string n, input string f,
                      input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %b want %b", n, f, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(mon_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp8(e.name, "a", a_output, e.a);
        cmp8(e.name, "b", b_output, e.b);
        cmp8(e.name, "bus", bus_w, e.bus);
        cmp1(e.name, "flag_Z", flag_Z, e.fz);
        cmp1(e.name, "flag_N", flag_N, e.fn);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    CLR_bar   = 1'b0;
    bus_input = 8'h00;
    L_A       = 1'b1;
    L_B       = 1'b1;
    E_A       = 1'b0;
    tick();
    chk("por", 8'h00, 8'h00, 1'b1, 1'b0);
    CLR_bar = 1'b1;
    tick();

    // Preload then reset mid-cycle with a load pending
    bus_input = 8'h55; L_A = 1'b0;
    tick();
    bus_input = 8'hAA; L_A = 1'b1; L_B = 1'b0;
    tick();
    L_B = 1'b1;
    chk("preload", 8'h55, 8'hAA, 1'b0, 1'b0);
    #2;
    bus_input = 8'h11; L_A = 1'b0; L_B = 1'b0;
    CLR_bar = 1'b0;
    #1;
    chk("rst_async", 8'h00, 8'h00, 1'b1, 1'b0);
    E_A = 1'b1;
    #1;
    chk("rst_bus_en", 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    chk("rst_wins", 8'h00, 8'h00, 1'b1, 1'b0);
    E_A = 1'b0; L_A = 1'b1; L_B = 1'b1;
    #1;
    CLR_bar = 1'b1;
    tick();

    // Separate loads, then hold over three edges
    bus_input = 8'd128; L_A = 1'b0;
    tick();
    bus_input = 8'd32; L_A = 1'b1; L_B = 1'b0;
    tick();
    L_B = 1'b1;
    chk("loads", 8'd128, 8'd32, 1'b0, 1'b1);
    bus_input = 8'hFF;
    repeat (3) tick();
    chk("hold3", 8'd128, 8'd32, 1'b0, 1'b1);

    // Bus drive toggle with A = 200
    bus_input = 8'd200; L_A = 1'b0;
    tick();
    L_A = 1'b1;
    chk("drv_off0", 8'hC8, 8'd32, 1'b0, 1'b1);
    E_A = 1'b1;
    #1;
    chk("drv_on", 8'hC8, 8'd32, 1'b0, 1'b1);
    E_A = 1'b0;
    #1;
    chk("drv_off1", 8'hC8, 8'd32, 1'b0, 1'b1);

    // Write-back of an adder sum while A drives the bus
    bus_input = 8'd128; L_A = 1'b0;
    tick();
    bus_input = 8'd160; E_A = 1'b1;
    #1;
    chk("wb_pre", 8'd128, 8'd32, 1'b0, 1'b1);
    tick();
    L_A = 1'b1;
    chk("wb_post", 8'd160, 8'd32, 1'b0, 1'b1);
    E_A = 1'b0;

    // Both registers capture the same bus value
    bus_input = 8'h7F; L_A = 1'b0; L_B = 1'b0;
    tick();
    L_A = 1'b1; L_B = 1'b1;
    chk("both", 8'h7F, 8'h7F, 1'b0, 1'b0);

    // Flag patterns
    bus_input = 8'h00; L_A = 1'b0;
    tick();
    chk("flag_zero", 8'h00, 8'h7F, 1'b1, 1'b0);
    bus_input = 8'h80;
    tick();
    L_A = 1'b1;
    chk("flag_neg", 8'h80, 8'h7F, 1'b0, 1'b1);
    bus_input = 8'h00; L_B = 1'b0;
    tick();
    L_B = 1'b1;
    chk("b_only", 8'h80, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 100 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_registers.md
# operand_registers

Holds the two 8-bit operands for the SAP-1 adder/subtractor: the accumulator (A) and the B register. Both load from the shared W bus on the rising clock edge. Both present their contents continuously to the adder/subtractor's `a_input` and `b_input`. The accumulator can also drive the bus through a tri-state output, which lets an adder result be written back into A and read out later.

## Interface
Parameters:
- `WIDTH`, default 8: data width of both registers and the bus. Only 8 is supported in SAP-1.

Ports:
- `CLK`  input  1  system clock; all state updates on the rising edge.
- `CLR_bar`  input  1  asynchronous, active-low reset.
- `bus_input`  input  WIDTH  W bus value sampled on loads.
- `L_A`  input  1  active-low accumulator load.
- `E_A`  input  1  active-high accumulator bus enable.
- `L_B`  input  1  active-low B register load.
- `a_output`  output  WIDTH  accumulator contents, to the adder/subtractor `a_input`.
- `b_output`  output  WIDTH  B register contents, to the adder/subtractor `b_input`.
- `bus_output`  output  WIDTH  accumulator contents when `E_A`=1, else high-impedance.
- `flag_Z`  output  1  zero flag (only with `FLAGS_EN`).
- `flag_N`  output  1  negative flag (only with `FLAGS_EN`).

## Operation
- Each register is `WIDTH` D flip-flops with a load mux. There is no other state apart from the optional flags.
- Accumulator update at each rising `CLK`:
  - `L_A`=0: A <= `bus_input`.
  - `L_A`=1: A holds.
- B register update at each rising `CLK`:
  - `L_B`=0: B <= `bus_input`.
  - `L_B`=1: B holds.
- `L_A`=0 and `L_B`=0 on the same edge: both registers capture the same `bus_input`.
- `a_output` = A and `b_output` = B at all times, independent of `E_A`.
- `bus_output`:
  - `E_A`=1: drives A.
  - `E_A`=0: all bits Z.
- `E_A`=1 together with `L_A`=0 is legal. A captures `bus_input`. `bus_output` shows the pre-edge value until the edge, then the new value.
- Reset (`CLR_bar`=0), asynchronous and taking effect immediately regardless of `CLK`:
  - A, B, `flag_Z` and `flag_N` are forced as follows: A=0, B=0, `flag_Z`=1 (reflects A=0), `flag_N`=0.
  - `bus_output` is still governed only by `E_A`: Z if `E_A`=0, 8'h00 if `E_A`=1.
- Reset asserted in the middle of a load: reset wins and the load is discarded.
- After `CLR_bar` rises, the first rising edge with a load asserted captures normally.
- Arithmetic: none in this block. Values are stored unsigned, with no width conversion.

## Timing
- Load latency is 1 cycle: data present at rising edge N appears on `a_output`/`b_output` after edge N.
- The `bus_output` enable path is purely combinational from `E_A` and A. There is no registered enable.
- Asynchronous reset: outputs change with no clock edge required.
- `bus_input`, `L_A` and `L_B` must be stable around the rising edge, under standard setup/hold.
- The block imposes no handshake. The controller/sequencer must ensure at most one bus driver per cycle.

## Configuration
- Macro: `OPERAND_REGISTERS_FLAGS_EN`.
- Defined:
  - Adds two flag flip-flops, updated only on edges where `L_A`=0.
  - `flag_Z` <= (`bus_input` == 0).
  - `flag_N` <= `bus_input[WIDTH-1]`.
  - Flags hold when `L_A`=1.
  - Reset values: `flag_Z`=1, `flag_N`=0.
- Undefined:
  - `flag_Z` and `flag_N` are tied to constant 0.
  - No flag flip-flops are inferred.
  - The ports remain so that instantiations are identical.

## Test plan
- Reset: `CLR_bar`=0 mid-cycle with A=8'h55 and B=8'hAA → `a_output`=8'h00 and `b_output`=8'h00 immediately. `flag_Z`=1 if `FLAGS_EN`, else 0. `bus_output`=Z with `E_A`=0.
- Loads: `bus_input`=8'd128 with `L_A`=0 for one edge, then 8'd32 with `L_B`=0 → `a_output`=8'd128, `b_output`=8'd32. Both hold over 3 further edges with `L_A`=`L_B`=1.
- Bus drive: A=8'd200, then `E_A` toggled 0→1→0 → `bus_output`=Z, then 8'hC8, then Z. `a_output` stays 8'hC8 throughout.
- Write-back: A=8'd128 and B=8'd32. Feed the adder sum 8'd160 on `bus_input` with `L_A`=0 and `E_A`=1 → after the edge `a_output`=8'd160 and `bus_output`=8'd160. `b_output` is unchanged at 8'd32.
- Simultaneous load: `L_A`=`L_B`=0 with `bus_input`=8'h7F → both outputs 8'h7F after one edge.
- Flags (`FLAGS_EN`):
  - Load 8'h00 → `flag_Z`=1, `flag_N`=0.
  - Load 8'h80 → `flag_Z`=0, `flag_N`=1.
  - A B-only load of 8'h00 leaves the flags unchanged.
